stk_pipe_dl: RTL and testbench

STK_PIPE_DL -- requirements
Module: stk_pipe_dl

---
 rtl/stk_pkg.sv | 23 ++
 rtl/stk_pipe_dl_q.sv | 62 ++++++
 rtl/stk_pipe_dl.sv | 88 ++++++++
 tb/tb_stk_pipe_dl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/stk_pkg.sv
// Shared types and sizing for the descriptor-stack return path.
// DL_QUAR_CYCLES only matters when STK_PIPE_DL_QUARANTINE_EN is defined.
package stk_pkg;

   localparam int PTR_W          = 8;
   localparam int DL_Q_N         = 4;
   localparam int DL_QUAR_CYCLES = 3;

   localparam int DL_IDX_W = (DL_Q_N > 1) ? $clog2(DL_Q_N) : 1;
   localparam int DL_CNT_W = $clog2(DL_Q_N + 1);
   localparam int DL_AGE_W = (DL_QUAR_CYCLES > 0) ? $clog2(DL_QUAR_CYCLES + 1) : 1;

   typedef logic [PTR_W-1:0]    ptr_t;
   typedef logic [DL_IDX_W-1:0] dl_idx_t;
   typedef logic [DL_CNT_W-1:0] dl_cnt_t;
   typedef logic [DL_AGE_W-1:0] dl_age_t;

   // Ring index advance; DL_Q_N need not be a power of two.
   function automatic dl_idx_t dl_next_idx(input dl_idx_t idx);
      return (idx == DL_IDX_W'(DL_Q_N - 1)) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/stk_pipe_dl_q.sv
// Return-queue FIFO: DL_Q_N pointer entries, ring indices and occupancy count.
// Latency: write visible at head the next cycle. Backpressure: full/empty from registered count.
// Index ports exist only when STK_PIPE_DL_QUARANTINE_EN is defined (age tracking needs them).
module stk_pipe_dl_q
   import stk_pkg::*;
(
   input  logic    clk,
   input  logic    arst_n,
   input  logic    wr_en,
   input  ptr_t    wr_ptr,
   input  logic    rd_en,
   output ptr_t    rd_ptr,
`ifdef STK_PIPE_DL_QUARANTINE_EN
   output dl_idx_t wr_idx,
   output dl_idx_t rd_idx,
`endif
   output logic    full,
   output logic    empty
);

   ptr_t    mem [DL_Q_N];
   dl_idx_t wr_q;
   dl_idx_t rd_q;
   dl_cnt_t count;

   // Storage carries no reset; validity is tracked solely by count.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_q] <= wr_ptr;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         count <= '0;
      end else begin
         if (wr_en) begin
            wr_q <= dl_next_idx(wr_q);
         end
         if (rd_en) begin
            rd_q <= dl_next_idx(rd_q);
         end
         if (wr_en && !rd_en) begin
            count <= count + 1'b1;
         end else if (!wr_en && rd_en) begin
            count <= count - 1'b1;
         end
      end
   end

   assign rd_ptr = mem[rd_q];
   assign full   = (count == DL_CNT_W'(DL_Q_N));
   assign empty  = (count == '0);

`ifdef STK_PIPE_DL_QUARANTINE_EN
   assign wr_idx = wr_q;
   assign rd_idx = rd_q;
`endif

endmodule

// File: rtl/stk_pipe_dl.sv
// Deferred-free return path: queues freed pointers and hands them back to the allocator in order.
// Latency: write-to-o_dealloc_vld 2 cycles, DL_QUAR_CYCLES+2 with STK_PIPE_DL_QUARANTINE_EN.
// Backpressure: o_dl_busy when the queue is full; writes presented while busy are dropped.
module stk_pipe_dl
   import stk_pkg::*;
(
   input  logic clk,
   input  logic arst_n,
   input  logic i_dl_vld,
   input  ptr_t i_dl_ptr,
   output logic o_dl_busy,
   output logic o_dl_empty,
   output logic o_dealloc_vld,
   output ptr_t o_dealloc_ptr
);

   logic wr_en;
   logic rd_en;
   logic q_full;
   logic q_empty;
   ptr_t head_ptr;

`ifdef STK_PIPE_DL_QUARANTINE_EN
   dl_idx_t wr_idx;
   dl_idx_t rd_idx;
   dl_age_t age [DL_Q_N];
`endif

   assign wr_en = i_dl_vld && !q_full;

   stk_pipe_dl_q u_q (
      .clk    (clk),
      .arst_n (arst_n),
      .wr_en  (wr_en),
      .wr_ptr (i_dl_ptr),
      .rd_en  (rd_en),
      .rd_ptr (head_ptr),
`ifdef STK_PIPE_DL_QUARANTINE_EN
      .wr_idx (wr_idx),
      .rd_idx (rd_idx),
`endif
      .full   (q_full),
      .empty  (q_empty)
   );

`ifdef STK_PIPE_DL_QUARANTINE_EN
   // Ages of idle slots also count up; harmless since only a valid head is examined.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < DL_Q_N; i++) begin
            age[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DL_Q_N; i++) begin
            if (wr_en && (wr_idx == DL_IDX_W'(i))) begin
               age[i] <= '0;
            end else if (age[i] != DL_AGE_W'(DL_QUAR_CYCLES)) begin
               age[i] <= age[i] + 1'b1;
            end
         end
      end
   end

   assign rd_en = !q_empty && (age[rd_idx] == DL_AGE_W'(DL_QUAR_CYCLES));
`else
   assign rd_en = !q_empty;
`endif

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         o_dealloc_vld <= 1'b0;
         o_dealloc_ptr <= '0;
      end else begin
         o_dealloc_vld <= rd_en;
         if (rd_en) begin
            o_dealloc_ptr <= head_ptr;
         end
      end
   end

   assign o_dl_busy  = q_full;
   assign o_dl_empty = q_empty;

   a_no_write_when_busy: assert property (@(posedge clk) disable iff (!arst_n)
                                          !(i_dl_vld && o_dl_busy))
      else $error("stk_pipe_dl: pointer write dropped while busy");

endmodule

// File: tb/tb_stk_pipe_dl.sv
// Directed and randomized checks of stk_pipe_dl against an out-cycle queue model.
module tb_stk_pipe_dl;
   import stk_pkg::*;

`ifdef STK_PIPE_DL_QUARANTINE_EN
   localparam int LAT = DL_QUAR_CYCLES + 2;
`else
   localparam int LAT = 2;
`endif

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   logic i_dl_vld = 1'b0;
   ptr_t i_dl_ptr = '0;
   logic o_dl_busy;
   logic o_dl_empty;
   logic o_dealloc_vld;
   ptr_t o_dealloc_ptr;

   stk_pipe_dl dut (
      .clk           (clk),
      .arst_n        (arst_n),
      .i_dl_vld      (i_dl_vld),
      .i_dl_ptr      (i_dl_ptr),
      .o_dl_busy     (o_dl_busy),
      .o_dl_empty    (o_dl_empty),
      .o_dealloc_vld (o_dealloc_vld),
      .o_dealloc_ptr (o_dealloc_ptr)
   );

   always #5 clk = ~clk;

   // Model: each accepted pointer leaves at max(write+LAT, previous departure+1).
   typedef struct {
      ptr_t ptr;
      int   out;
   } ent_t;

   ent_t mq[$];
   int   cyc      = 0;
   int   last_out = -100;
   ptr_t exp_ptr  = '0;
   int   errors   = 0;
   int   checks   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // Drive one cycle, advance the clock, then compare every output against the model.
   task automatic tick(input logic wr, input ptr_t p);
      int   o;
      logic exp_vld;
      i_dl_vld = wr;
      i_dl_ptr = p;
      if (wr && mq.size() < DL_Q_N) begin
         o = (cyc + LAT > last_out + 1) ? cyc + LAT : last_out + 1;
         mq.push_back('{ptr: p, out: o});
         last_out = o;
      end
      @(posedge clk);
      cyc++;
      #1;
      i_dl_vld = 1'b0;
      exp_vld = (mq.size() > 0) && (mq[0].out == cyc);
      if (exp_vld) begin
         exp_ptr = mq[0].ptr;
         void'(mq.pop_front());
      end
      chk("dealloc_vld", 32'(o_dealloc_vld), 32'(exp_vld));
      chk("dealloc_ptr", 32'(o_dealloc_ptr), 32'(exp_ptr));
      chk("dl_empty",    32'(o_dl_empty),    32'(mq.size() == 0));
      chk("dl_busy",     32'(o_dl_busy),     32'(mq.size() == DL_Q_N));
   endtask

   task automatic do_reset(input int n);
      arst_n = 1'b0;
      #1;
      mq.delete();
      last_out = -100;
      exp_ptr  = '0;
      chk("rst_empty", 32'(o_dl_empty),    32'd1);
      chk("rst_busy",  32'(o_dl_busy),     32'd0);
      chk("rst_vld",   32'(o_dealloc_vld), 32'd0);
      chk("rst_ptr",   32'(o_dealloc_ptr), 32'd0);
      repeat (n) begin
         @(posedge clk);
         cyc++;
      end
      @(negedge clk);
      arst_n = 1'b1;
   endtask

   initial begin
      // Reset and release
      do_reset(3);
      tick(1'b0, '0);

      // Single entry written at cycle 10
      while (cyc < 10) tick(1'b0, '0);
      tick(1'b1, 8'h05);
      repeat (LAT + 4) tick(1'b0, '0);

`ifdef STK_PIPE_DL_QUARANTINE_EN
      // Fill with no pop possible, then a dropped fifth write
      for (int i = 1; i <= 4; i++) tick(1'b1, ptr_t'(i));
      tick(1'b1, 8'hEE);
      repeat (LAT + 6) tick(1'b0, '0);
`endif

      // Streaming 0..15 on consecutive cycles
      for (int i = 0; i < 16; i++) tick(1'b1, ptr_t'(i));
      repeat (LAT + DL_Q_N + 2) tick(1'b0, '0);

      // Alternating write/idle for 3*DL_Q_N writes to exercise index wrap
      for (int i = 0; i < 3 * DL_Q_N; i++) begin
         tick(1'b1, ptr_t'(8'h40 + i));
         tick(1'b0, '0);
      end
      repeat (LAT + 4) tick(1'b0, '0);

      // Randomized traffic, writes gated by the model's view of busy
      for (int i = 0; i < 300; i++) begin
         tick(($urandom_range(0, 99) < 60) && (mq.size() < DL_Q_N), ptr_t'($urandom));
      end
      repeat (LAT + DL_Q_N + 2) tick(1'b0, '0);

      // Mid-run reset with pointers still held: none may reappear afterwards
      for (int i = 0; i < 3; i++) tick(1'b1, ptr_t'(8'hA0 + i));
      do_reset(2);
      repeat (LAT + DL_Q_N + 4) tick(1'b0, '0);

      // Post-reset traffic still flows correctly
      for (int i = 0; i < 6; i++) tick(1'b1, ptr_t'(8'hC0 + i));
      repeat (LAT + DL_Q_N + 4) tick(1'b0, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
